monster_object: RTL and testbench
=================================

Name: monster_object

Overview:
- Per-monster object controller that drives the drawing interface of a monster silhouette bitmap block.
- Converts the VGA scan position and the monster's top-left coordinate into a registered in-rectangle flag plus X/Y offsets.
- Runs the hit/explosion life-cycle that selects the monster or explosion bitmap through monsterIsHit, then blanks the monster and reports its death.
- Instantiated once per monster, between the monster movement logic and the silhouette/bitmap block.

Parameters:
- OBJECT_WIDTH, 32, rectangle width in pixels (1..64).
- OBJECT_HEIGHT, 32, rectangle height in pixels (1..64).
- EXPLOSION_FRAMES, 16, number of frames the explosion bitmap is shown (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pixelX  in  11  current scan column.
- pixelY  in  11  current scan row.
- topLeftX  in  11  monster rectangle left edge.
- topLeftY  in  11  monster rectangle top edge.
- startOfFrame  in  1  one-cycle pulse per video frame.
- collision  in  1  monster pixel overlapped by a player missile this cycle.
- respawn  in  1  one-cycle request to revive a dead monster.
- InsideRectangle  out  1  registered: previous-cycle pixel lies inside a live or exploding monster rectangle.
- offsetX  out  11  registered pixelX - topLeftX when inside, else 0.
- offsetY  out  11  registered pixelY - topLeftY when inside, else 0.
- monsterIsHit  out  1  high in EXPLODING state (selects explosion bitmap).
- monsterAlive  out  1  high in ALIVE state.
- monsterDeathPulse  out  1  one-cycle pulse on entry to DEAD (score event).

Behaviour:
- Reset (async, active-high): state=ALIVE, frame counter=0.
- Outputs during reset: InsideRectangle=0, offsetX=0, offsetY=0, monsterIsHit=0, monsterAlive=1, monsterDeathPulse=0.
- Rectangle test, comparison width:
  - Right/bottom bounds computed as 12-bit sums, so topLeft+size never wraps.
  - inside = pixelX>=topLeftX and pixelX<topLeftX+OBJECT_WIDTH, with the same test for Y.
- Rectangle outputs:
  - Latency exactly 1 clk from pixelX/pixelY/topLeft to InsideRectangle/offsets.
  - Offsets are 11-bit differences and are only nonzero when inside.
  - In DEAD, InsideRectangle, offsetX and offsetY are forced to 0 on the next registered update.
- ALIVE state:
  - collision=1 -> EXPLODING.
  - Frame counter cleared to 0.
  - respawn ignored.
- EXPLODING state:
  - Each startOfFrame increments the frame counter.
  - startOfFrame with counter==EXPLOSION_FRAMES-1 -> DEAD, counter cleared, monsterDeathPulse=1 for that one cycle.
  - collision and respawn ignored.
- DEAD state:
  - respawn=1 -> ALIVE.
  - collision ignored; startOfFrame ignored.
- State outputs (monsterIsHit, monsterAlive) are registered state decodes and change on the clock edge of the transition.
- Simultaneous events:
  - collision and respawn in ALIVE: go to EXPLODING.
  - collision and startOfFrame in ALIVE: go to EXPLODING with counter 0, not incremented.
  - respawn and startOfFrame in DEAD: go to ALIVE.
- Reset asserted mid-explosion returns to ALIVE immediately with no death pulse.
- Frame counter is 8 bits and never exceeds EXPLOSION_FRAMES-1.
- EXPLOSION_FRAMES=1: the first startOfFrame after the hit ends the explosion.

Test Plan:
- Rectangle offsets: topLeft=(100,50), pixel=(131,81) -> next cycle InsideRectangle=1, offsetX=31, offsetY=31.
- Rectangle edges: pixel=(132,81) -> InsideRectangle=0, offsets 0; pixel=(99,50) -> 0.
- Near-wrap: topLeftX=2040, pixelX=2047, Y inside -> InsideRectangle=1, offsetX=7; no false inside at pixelX=5.
- Explosion life-cycle:
  - collision pulse in ALIVE -> next cycle monsterIsHit=1, monsterAlive=0.
  - After 16 startOfFrame pulses -> DEAD and monsterDeathPulse high for exactly 1 cycle.
  - InsideRectangle stays 0 thereafter for any pixel.
- Ignored and simultaneous inputs:
  - collision during EXPLODING leaves the counter unaffected; explosion still lasts 16 frames.
  - respawn in ALIVE does nothing.
  - respawn in DEAD -> monsterAlive=1 next cycle.
- Reset mid-explosion: assert reset after 5 frames of EXPLODING -> outputs immediately monsterIsHit=0, monsterAlive=1, InsideRectangle=0; no death pulse at any time.

Source files
------------

// File: rtl/monster_object.sv
`default_nettype none
// ============================================================================
//  Module   : monster_object
//  Purpose  : Per-monster object controller. Registers the in-rectangle flag
//             and X/Y offsets for the monster silhouette bitmap, and runs the
//             ALIVE -> EXPLODING -> DEAD life-cycle with a frame-counted
//             explosion and a one-cycle death pulse for scoring.
//  Revision : 1.0 - initial release
// ============================================================================
module monster_object #(
   parameter int OBJECT_WIDTH     = 32,   // rectangle width  (1..64)
   parameter int OBJECT_HEIGHT    = 32,   // rectangle height (1..64)
   parameter int EXPLOSION_FRAMES = 16    // explosion length in frames (1..255)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic [10:0] topLeftX,
   input  logic [10:0] topLeftY,
   input  logic        startOfFrame,
   input  logic        collision,
   input  logic        respawn,
   output logic        InsideRectangle,
   output logic [10:0] offsetX,
   output logic [10:0] offsetY,
   output logic        monsterIsHit,
   output logic        monsterAlive,
   output logic        monsterDeathPulse
);

   // Rectangle extents widened to 12 bits so topLeft + size never wraps
   // around the 11-bit coordinate space.
   localparam logic [11:0] c_WIDTH12   = 12'(OBJECT_WIDTH);
   localparam logic [11:0] c_HEIGHT12  = 12'(OBJECT_HEIGHT);
   // Counter value on which the final explosion frame ends.
   localparam logic [7:0]  c_LAST_FRAME = 8'(EXPLOSION_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_ALIVE     = 2'd0,
      ST_EXPLODING = 2'd1,
      ST_DEAD      = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  frame_q, frame_d;
   logic        death_q, death_d;

   logic        inside_q, inside_d;
   logic [10:0] offx_q, offx_d;
   logic [10:0] offy_q, offy_d;

   logic [11:0] w_right;
   logic [11:0] w_bottom;
   logic        w_in_x;
   logic        w_in_y;
   logic        w_in_rect;

   // --------------------------------------------------------------------
   // Rectangle hit test. A dead monster is invisible, so the test is
   // suppressed while the state register holds DEAD.
   // --------------------------------------------------------------------
   assign w_right   = {1'b0, topLeftX} + c_WIDTH12;
   assign w_bottom  = {1'b0, topLeftY} + c_HEIGHT12;
   assign w_in_x    = (pixelX >= topLeftX) && ({1'b0, pixelX} < w_right);
   assign w_in_y    = (pixelY >= topLeftY) && ({1'b0, pixelY} < w_bottom);
   assign w_in_rect = w_in_x && w_in_y && (state_q != ST_DEAD);

   // Next values of the rectangle outputs: offsets only when inside.
   always_comb begin
      inside_d = w_in_rect;
      offx_d   = 11'd0;
      offy_d   = 11'd0;
      if (w_in_rect) begin
         offx_d = pixelX - topLeftX;
         offy_d = pixelY - topLeftY;
      end
   end

   // Life-cycle next-state logic and explosion frame counting.
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      death_d = 1'b0;
      case (state_q)
         ST_ALIVE: begin
            // Counter held at zero so an explosion always starts fresh;
            // respawn has no meaning for a live monster.
            frame_d = 8'd0;
            if (collision) begin
               state_d = ST_EXPLODING;
            end
         end
         ST_EXPLODING: begin
            // Further hits while exploding are ignored.
            if (startOfFrame) begin
               if (frame_q == c_LAST_FRAME) begin
                  state_d = ST_DEAD;
                  frame_d = 8'd0;
                  death_d = 1'b1;
               end else begin
                  frame_d = frame_q + 8'd1;
               end
            end
         end
         ST_DEAD: begin
            frame_d = 8'd0;
            if (respawn) begin
               state_d = ST_ALIVE;
            end
         end
         default: begin
            state_d = ST_ALIVE;
            frame_d = 8'd0;
         end
      endcase
   end

   // State, counter and death pulse registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_ALIVE;
         frame_q <= 8'd0;
         death_q <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         death_q <= death_d;
      end
   end

   // Registered rectangle outputs, one clock behind the scan position.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inside_q <= 1'b0;
         offx_q   <= 11'd0;
         offy_q   <= 11'd0;
      end else begin
         inside_q <= inside_d;
         offx_q   <= offx_d;
         offy_q   <= offy_d;
      end
   end

   assign InsideRectangle   = inside_q;
   assign offsetX           = offx_q;
   assign offsetY           = offy_q;
   assign monsterIsHit      = (state_q == ST_EXPLODING);
   assign monsterAlive      = (state_q == ST_ALIVE);
   assign monsterDeathPulse = death_q;

endmodule
`default_nettype wire

// File: tb/tb_monster_object.sv
`default_nettype none
// ============================================================================
//  Module   : tb_monster_object
//  Purpose  : Directed scoreboard bench for monster_object. Stimulus pushes
//             the expected registered response of each driven cycle; a
//             monitor pops one entry after every rising edge and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_monster_object;

   logic        clk;
   logic        reset;
   logic [10:0] pixelX, pixelY, topLeftX, topLeftY;
   logic        startOfFrame, collision, respawn;
   logic        InsideRectangle;
   logic [10:0] offsetX, offsetY;
   logic        monsterIsHit, monsterAlive, monsterDeathPulse;

   monster_object #(
      .OBJECT_WIDTH    (32),
      .OBJECT_HEIGHT   (32),
      .EXPLOSION_FRAMES(16)
   ) u_dut (
      .clk              (clk),
      .reset            (reset),
      .pixelX           (pixelX),
      .pixelY           (pixelY),
      .topLeftX         (topLeftX),
      .topLeftY         (topLeftY),
      .startOfFrame     (startOfFrame),
      .collision        (collision),
      .respawn          (respawn),
      .InsideRectangle  (InsideRectangle),
      .offsetX          (offsetX),
      .offsetY          (offsetY),
      .monsterIsHit     (monsterIsHit),
      .monsterAlive     (monsterAlive),
      .monsterDeathPulse(monsterDeathPulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0]  mask;   // 0 inside,1 offX,2 offY,3 hit,4 alive,5 death
      logic        ins;
      logic [10:0] ox;
      logic [10:0] oy;
      logic        hit;
      logic        alive;
      logic        dp;
      logic [15:0] tag;
   } exp_t;

   localparam logic [5:0] M_ALL = 6'b111111;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] tag      = 16'd0;

   task automatic chk(input string nm, input int t, input logic [10:0] act, input logic [10:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec %0d: got %0d expected %0d", nm, t, act, exp);
      end
   endtask

   // One stimulus cycle plus the response expected after the next edge.
   task automatic drive(input logic [10:0] px, input logic [10:0] py,
                        input logic [10:0] tx, input logic [10:0] ty,
                        input logic sof, input logic col, input logic resp,
                        input logic ins, input logic [10:0] ox, input logic [10:0] oy,
                        input logic hit, input logic alive, input logic dp);
      exp_t e;
      @(negedge clk);
      pixelX = px; pixelY = py; topLeftX = tx; topLeftY = ty;
      startOfFrame = sof; collision = col; respawn = resp;
      e.mask = M_ALL; e.ins = ins; e.ox = ox; e.oy = oy;
      e.hit = hit; e.alive = alive; e.dp = dp; e.tag = tag;
      sb.push_back(e);
      tag = tag + 16'd1;
   endtask

   // Monitor: compare registered outputs just after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.mask[0]) chk("inside", int'(e.tag), {10'd0, InsideRectangle}, {10'd0, e.ins});
            if (e.mask[1]) chk("offsetX", int'(e.tag), offsetX, e.ox);
            if (e.mask[2]) chk("offsetY", int'(e.tag), offsetY, e.oy);
            if (e.mask[3]) chk("hit", int'(e.tag), {10'd0, monsterIsHit}, {10'd0, e.hit});
            if (e.mask[4]) chk("alive", int'(e.tag), {10'd0, monsterAlive}, {10'd0, e.alive});
            if (e.mask[5]) chk("death", int'(e.tag), {10'd0, monsterDeathPulse}, {10'd0, e.dp});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      pixelX = 11'd0; pixelY = 11'd0; topLeftX = 11'd0; topLeftY = 11'd0;
      startOfFrame = 1'b0; collision = 1'b0; respawn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_inside", -1, {10'd0, InsideRectangle}, 11'd0);
      chk("rst_offX",   -1, offsetX, 11'd0);
      chk("rst_offY",   -1, offsetY, 11'd0);
      chk("rst_hit",    -1, {10'd0, monsterIsHit}, 11'd0);
      chk("rst_alive",  -1, {10'd0, monsterAlive}, 11'd1);
      chk("rst_death",  -1, {10'd0, monsterDeathPulse}, 11'd0);
      @(negedge clk);
      reset = 1'b0;

      // Rectangle offsets and edges with topLeft (100,50).
      drive(11'd131, 11'd81, 11'd100, 11'd50, 0, 0, 0, 1, 11'd31, 11'd31, 0, 1, 0);
      drive(11'd132, 11'd81, 11'd100, 11'd50, 0, 0, 0, 0, 11'd0,  11'd0,  0, 1, 0);
      drive(11'd99,  11'd50, 11'd100, 11'd50, 0, 0, 0, 0, 11'd0,  11'd0,  0, 1, 0);
      drive(11'd100, 11'd50, 11'd100, 11'd50, 0, 0, 0, 1, 11'd0,  11'd0,  0, 1, 0);
      drive(11'd131, 11'd82, 11'd100, 11'd50, 0, 0, 0, 0, 11'd0,  11'd0,  0, 1, 0);
      // Near the right edge of the coordinate space.
      drive(11'd2047, 11'd60, 11'd2040, 11'd50, 0, 0, 0, 1, 11'd7, 11'd10, 0, 1, 0);
      drive(11'd5,    11'd60, 11'd2040, 11'd50, 0, 0, 0, 0, 11'd0, 11'd0,  0, 1, 0);
      // Respawn while alive does nothing.
      drive(11'd110, 11'd60, 11'd100, 11'd50, 0, 0, 1, 1, 11'd10, 11'd10, 0, 1, 0);
      // Collision + respawn + startOfFrame in ALIVE: explode, counter stays 0.
      drive(11'd131, 11'd81, 11'd100, 11'd50, 1, 1, 1, 1, 11'd31, 11'd31, 1, 0, 0);
      // Sixteen frames, with hits and respawns sprinkled in that must be ignored.
      for (int i = 0; i < 16; i++) begin
         drive(11'd131, 11'd81, 11'd100, 11'd50, 1, (i == 3), 0,
               1, 11'd31, 11'd31, (i != 15), 0, (i == 15));
         if (i < 15)
            drive(11'd131, 11'd81, 11'd100, 11'd50, 0, 1, 1, 1, 11'd31, 11'd31, 1, 0, 0);
      end
      // Dead: invisible, pulse gone, collision/startOfFrame ignored.
      drive(11'd131, 11'd81, 11'd100, 11'd50, 1, 1, 0, 0, 11'd0, 11'd0, 0, 0, 0);
      drive(11'd100, 11'd50, 11'd100, 11'd50, 0, 1, 0, 0, 11'd0, 11'd0, 0, 0, 0);
      // Respawn + startOfFrame in DEAD revives.
      drive(11'd110, 11'd60, 11'd100, 11'd50, 1, 0, 1, 0, 11'd0,  11'd0,  0, 1, 0);
      drive(11'd110, 11'd60, 11'd100, 11'd50, 0, 0, 0, 1, 11'd10, 11'd10, 0, 1, 0);
      // New explosion, five frames, then reset mid-explosion.
      drive(11'd110, 11'd60, 11'd100, 11'd50, 0, 1, 0, 1, 11'd10, 11'd10, 1, 0, 0);
      for (int i = 0; i < 5; i++)
         drive(11'd110, 11'd60, 11'd100, 11'd50, 1, 0, 0, 1, 11'd10, 11'd10, 1, 0, 0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_hit",    -2, {10'd0, monsterIsHit}, 11'd0);
      chk("mid_rst_alive",  -2, {10'd0, monsterAlive}, 11'd1);
      chk("mid_rst_inside", -2, {10'd0, InsideRectangle}, 11'd0);
      chk("mid_rst_death",  -2, {10'd0, monsterDeathPulse}, 11'd0);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("hold_rst_death", -3, {10'd0, monsterDeathPulse}, 11'd0);
         chk("hold_rst_alive", -3, {10'd0, monsterAlive}, 11'd1);
      end
      @(negedge clk);
      startOfFrame = 1'b0;
      reset = 1'b0;
      // Frames keep coming after reset: monster stays alive, no pulse.
      for (int i = 0; i < 17; i++)
         drive(11'd110, 11'd60, 11'd100, 11'd50, 1, 0, 0, 1, 11'd10, 11'd10, 0, 1, 0);

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      #2;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending entries expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
